// File: rtl/lbuf_pingpong_if.sv
// Sprite/display bus of the ping-pong line buffer; master is the pipeline side, slave the buffer.
interface lbuf_pingpong_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          swap;
  logic          wen;
  logic [AW-1:0] wad;
  logic [DW-1:0] wdi;
  logic          ren;
  logic [AW-1:0] rad;
  logic [DW-1:0] rdo;
  logic          rvld;
  logic          wbank;

  modport master (
    output swap, wen, wad, wdi, ren, rad,
    input  rdo, rvld, wbank
  );

  modport slave (
    input  swap, wen, wad, wdi, ren, rad,
    output rdo, rvld, wbank
  );
endinterface

// File: rtl/lbuf_pingpong.sv
// Ping-pong sprite line buffer, clear-behind-read display bank; LBUF_PRIO_EN selects first-writer-wins.
// Read latency 1 cycle, write latency 2 edges; no backpressure, both ports accept every cycle.
module lbuf_pingpong #(
  parameter int            AW    = 9,
  parameter int            DW    = 8,
  parameter logic [DW-1:0] TRANS = '0,
  parameter logic [DW-1:0] CLRV  = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  lbuf_pingpong_if.slave  bus
);

  localparam int DEPTH = 2 ** (AW + 1);

  // Both banks share one array; the bank bit is the index MSB.
  logic [DW-1:0] mem_q [DEPTH];

  logic          wbank_q, wbank_d;
  logic          rvld_q;
  logic [DW-1:0] rdo_q;
  logic          s2_vld_q, s2_vld_d;
  logic [AW:0]   s2_idx_q;
  logic [DW-1:0] s2_dat_q;

  logic [AW:0]   s1_idx;
  logic [AW:0]   rd_idx;
  logic          s2_commit;

  assign s1_idx   = {wbank_q, bus.wad};
  assign rd_idx   = {~wbank_q, bus.rad};
  assign s2_vld_d = bus.wen && (bus.wdi != TRANS);
  assign wbank_d  = wbank_q ^ bus.swap;

`ifdef LBUF_PRIO_EN
  logic [DW-1:0] s2_old_q;
  logic [DW-1:0] s1_old;

  // A commit landing on the word being sampled must be seen, or back-to-back writes both win.
  always_comb begin
    s1_old = mem_q[s1_idx];
    if (s2_commit && (s2_idx_q == s1_idx)) begin
      s1_old = s2_dat_q;
    end
  end

  assign s2_commit = s2_vld_q && (s2_old_q == CLRV);

  always_ff @(posedge clk_i) begin
    if (s2_vld_d) begin
      s2_old_q <= s1_old;
    end
  end
`else
  assign s2_commit = s2_vld_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wbank_q  <= 1'b0;
      rvld_q   <= 1'b0;
      rdo_q    <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      wbank_q  <= wbank_d;
      rvld_q   <= bus.ren;
      s2_vld_q <= s2_vld_d;
      if (bus.ren) begin
        rdo_q <= mem_q[rd_idx];
      end
    end
  end

  // Stage-2 write is ordered after the clear so a straddling write to the old bank survives.
  always_ff @(posedge clk_i) begin
    if (bus.ren) begin
      mem_q[rd_idx] <= CLRV;
    end
    if (s2_commit) begin
      mem_q[s2_idx_q] <= s2_dat_q;
    end
    if (s2_vld_d) begin
      s2_idx_q <= s1_idx;
      s2_dat_q <= bus.wdi;
    end
  end

  assign bus.rdo   = rdo_q;
  assign bus.rvld  = rvld_q;
  assign bus.wbank = wbank_q;

endmodule

// File: doc/lbuf_pingpong.md
# lbuf_pingpong

Parametrised ping-pong sprite line buffer for the video pipeline, placed between the sprite engine and the pixel mixer. One bank is written by the sprite engine for the next scanline while the other is read out for display and cleared behind the read. Each bank is 2**AW words of DW bits. Transparent pixels are dropped on write, and an optional first-writer-wins priority mode is available.

## Interface
- AW, 9: address width per bank (2**AW pixels per line)
- DW, 8: pixel width
- TRANS, 0: pixel value never written (transparent key)
- CLRV, 0: value written back after each display read
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- SWAP  in  1  one-cycle pulse at line end; exchanges the banks
- WEN  in  1  sprite write strobe
- WAD  in  AW  sprite write address
- WDI  in  DW  sprite pixel
- REN  in  1  display read strobe
- RAD  in  AW  display read address
- RDO  out  DW  display pixel
- RVLD  out  1  RDO valid strobe
- WBANK  out  1  bank currently selected for writing (display reads !WBANK)

## Operation
- Reset: WBANK=0, RDO=0, RVLD=0, write pipeline empty.
  - RAM contents are undefined after reset.
  - Before the first display line, one full read pass of each bank is required to reach CLRV.
- SWAP: WBANK toggles on the edge where SWAP=1.
- Display port:
  - On an edge with REN=1, the word at RAD in bank !WBANK is read and CLRV is written to the same location on the same edge (read-first).
  - RDO receives the old data. RVLD=1 on the following cycle, 0 otherwise.
  - RDO holds its value when REN=0.
- Write port, stage 1 (edge with WEN=1 and WDI!=TRANS):
  - Captures WAD, WDI and the current WBANK as the target bank.
  - WDI==TRANS drops the write and no stage is occupied.
- Write port, stage 2 (next edge):
  - Commits WDI to the latched bank and address, subject to the Configuration rule.
- A write issued before SWAP commits to the bank latched at issue, even if SWAP occurs between stage 1 and stage 2.
- Write and display ports never address the same bank in the same cycle, except for an in-flight stage-2 write to the old bank after SWAP.
  - In that case the write commits and the display read of the same address returns pre-write data.
  - Software must not rely on that pixel.
- Address arithmetic is plain AW-bit indexing. There is no wrap logic; WAD and RAD cover the full 0..2**AW-1 range.

## Timing
- Display read latency is 1 cycle (REN at edge n → RDO/RVLD valid after edge n).
- Write latency is 2 edges (WEN at edge n → RAM updated at edge n+1).
- Full throughput on both ports: one write and one read per cycle, back-to-back, with no stall.
- SWAP coinciding with REN or WEN:
  - The bank select used on that edge is the pre-toggle WBANK.
  - The new WBANK applies from the next edge.
- Reset mid-line: the pending stage-2 write is discarded and RVLD drops immediately (asynchronous).

## Configuration
- LBUF_PRIO_EN defined (first-writer-wins priority):
  - Stage 1 also reads the target word. Stage 2 commits only if that word equals CLRV.
  - Forwarding rule: if stage 2 commits to the same bank/address that stage 1 is reading in the same cycle, stage 1 sees the committed value, not stale RAM.
  - The earlier sprite therefore wins even for back-to-back writes to one pixel.
- LBUF_PRIO_EN undefined (last-writer-wins):
  - Stage 2 commits unconditionally.
  - No write-path RAM read and no forwarding logic.

## Test plan
- Reset/swap: assert RST_N=0 mid-write → RVLD=0, WBANK=0, pending write lost. Release, pulse SWAP twice → WBANK 1 then 0.
- Clear-on-read: write 0x35 at addr 10 in bank 0, SWAP, REN at addr 10 → RDO=0x35, RVLD=1 next cycle. A second read of addr 10 → RDO=CLRV (0x00).
- Transparency: write 0x00 (TRANS) at addr 5 over existing 0x22, SWAP, read addr 5 → 0x22.
- Priority, LBUF_PRIO_EN defined: back-to-back writes 0x11 then 0x22 to addr 7, SWAP, read → 0x11. Same test with the macro undefined → 0x22.
- SWAP straddle: WEN 0x44 at addr 3 on the edge before SWAP → after two SWAPs, reading addr 3 returns nothing, i.e. CLRV. Reading addr 3 right after the first SWAP returns 0x44 (committed to bank 0).
- Throughput: stream 512 writes and 512 reads with REN/WEN held high for the whole line (AW=9) → every pixel read back correctly and the whole display bank equals CLRV afterwards.
